// File: rtl/fifo_ptr_pkg.sv
`default_nettype none
// ============================================================================
// Package   : fifo_ptr_pkg
// Purpose   : Shared pointer helpers for the async FIFO pointer blocks
//             (write-side fifo_wptr_full and its read-side counterpart).
// Contents  : PTR_W_MAX       - widest pointer the helpers handle
//             SYNC_STAGES_MAX - deepest legal pointer synchroniser
//             bin2gray()      - binary to reflected Gray code
//             gray2bin()      - reflected Gray code to binary
// Usage     : Callers zero-extend pointers to PTR_W_MAX bits and size-cast
//             the result back. Leading zeros do not change either transform.
// Revision  : 1.0 - initial release
// ============================================================================
package fifo_ptr_pkg;

    localparam int PTR_W_MAX       = 32;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_ptr_pkg
`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
`default_nettype none
// ============================================================================
// Interface : fifo_wptr_full_if
// Purpose   : Write-side pointer bus between a producer and fifo_wptr_full.
// Signals   : wr_en       producer write request
//             rd_gptr     read pointer in Gray code (read clock domain)
//             wr_addr     RAM write address
//             wr_gptr     registered Gray write pointer to the read domain
//             wr_push     RAM write strobe
//             full        registered full flag
//             ovf         sticky overflow flag
//             almost_full registered almost-full flag (FIFO_WPTR_AFULL_EN)
// Modports  : master - producer side, slave - pointer block side
// Macro     : FIFO_WPTR_AFULL_EN adds almost_full
// Revision  : 1.0 - initial release
// ============================================================================
interface fifo_wptr_full_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_gptr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_gptr;
    logic              wr_push;
    logic              full;
    logic              ovf;
`ifdef FIFO_WPTR_AFULL_EN
    logic              almost_full;
`endif

    modport master (
        output wr_en, rd_gptr,
        input  wr_addr, wr_gptr, wr_push, full, ovf
`ifdef FIFO_WPTR_AFULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  wr_en, rd_gptr,
        output wr_addr, wr_gptr, wr_push, full, ovf
`ifdef FIFO_WPTR_AFULL_EN
        , output almost_full
`endif
    );

endinterface : fifo_wptr_full_if
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module    : ptr_sync
// Purpose   : Multi-bit flop chain bringing a Gray-coded pointer into the
//             local clock domain. Only one bit changes per pointer step, so
//             a plain chain is safe; no logic may sit between the stages.
// Ports     : clk     local clock
//             rst_n   synchronous active-low reset, clears every stage
//             i_gptr  Gray pointer from the remote domain
//             o_gptr  synchronised Gray pointer
// Params    : WIDTH   pointer width
//             STAGES  chain depth, 2..SYNC_STAGES_MAX
// Revision  : 1.0 - initial release
// ============================================================================
module ptr_sync
    import fifo_ptr_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_gptr,
    output logic      [WIDTH-1:0] o_gptr
);

    logic [WIDTH-1:0] r_stage [STAGES];

    if (STAGES < 2 || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync: STAGES must be in 2..%0d", SYNC_STAGES_MAX);
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst_n) r_stage[i] <= '0;
                else        r_stage[i] <= i_gptr;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rst_n) r_stage[i] <= '0;
                else        r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_gptr = r_stage[STAGES-1];

endmodule : ptr_sync
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module    : fifo_wptr_full
// Purpose   : Write-side pointer and full-flag generator for an async FIFO.
//             Keeps an (ADDR_W+1)-bit binary write pointer, publishes it as a
//             registered Gray code, synchronises the read Gray pointer and
//             raises a registered, pessimistic full flag.
// Ports     : clk    write-domain clock
//             rst_n  synchronous active-low reset
//             wif    fifo_wptr_full_if.slave:
//                      in : wr_en, rd_gptr
//                      out: wr_addr, wr_gptr, wr_push, full, ovf,
//                           almost_full (FIFO_WPTR_AFULL_EN only)
// Params    : ADDR_W      FIFO address width (depth 2**ADDR_W), >= 2
//             SYNC_STAGES read-pointer synchroniser depth, 2..4
//             AFULL_TH    almost-full margin (FIFO_WPTR_AFULL_EN only)
// Macro     : FIFO_WPTR_AFULL_EN enables the almost-full flag
// Revision  : 1.0 - initial release
// ============================================================================
module fifo_wptr_full
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fifo_wptr_full_if.slave  wif
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gptr;
    logic          r_full;
    logic          r_ovf;

    logic          w_push;
    logic [PW-1:0] w_bin_nxt;
    logic [PW-1:0] w_gnxt;
    logic [PW-1:0] w_rq_gptr;
    logic          w_full_nxt;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_gptr (wif.rd_gptr),
        .o_gptr (w_rq_gptr)
    );

    // Push is gated by the registered flag, so the push that fills the FIFO
    // also raises full at the same edge and nothing can slip in after it.
    assign w_push    = wif.wr_en & ~r_full;
    assign w_bin_nxt = r_bin + {{ADDR_W{1'b0}}, w_push};
    assign w_gnxt    = PW'(bin2gray(PTR_W_MAX'(w_bin_nxt)));

    // Full when the writer is one lap ahead: in Gray form that is the top
    // two bits inverted and the rest equal.
    assign w_full_nxt = (w_gnxt == {~w_rq_gptr[ADDR_W:ADDR_W-1], w_rq_gptr[ADDR_W-2:0]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gptr <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gptr <= w_gnxt;
            r_full <= w_full_nxt;
            r_ovf  <= r_ovf | (wif.wr_en & r_full);
        end
    end

    assign wif.wr_addr = r_bin[ADDR_W-1:0];
    assign wif.wr_gptr = r_gptr;
    assign wif.wr_push = w_push;
    assign wif.full    = r_full;
    assign wif.ovf     = r_ovf;

`ifdef FIFO_WPTR_AFULL_EN
    localparam logic [PW-1:0] c_afull_lvl = PW'((2 ** ADDR_W) - AFULL_TH);

    logic [PW-1:0] w_rq_bin;
    logic [PW-1:0] w_level;
    logic          r_afull;

    assign w_rq_bin = PW'(gray2bin(PTR_W_MAX'(w_rq_gptr)));
    // Modulo subtraction gives the occupancy even across pointer wrap.
    assign w_level  = w_bin_nxt - w_rq_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) r_afull <= 1'b0;
        else        r_afull <= (w_level >= c_afull_lvl);
    end

    assign wif.almost_full = r_afull;
`endif

endmodule : fifo_wptr_full
`default_nettype wire
